// File: rtl/registro_desplazable.sv
// Universal shift register: parallel load, serial shift, circular rotate either direction.
// Latency: one clk edge from inputs to Q/S_OUT; ZERO (optional) is combinational from Q.
// Backpressure: none; ENB=0 freezes Q and S_OUT, otherwise every edge performs MODO.
//
// Optional build macro: REGISTRO_ZERO_FLAG_EN adds output ZERO (1 when Q is all zeros).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset (clears Q and S_OUT, wins over ENB/MODO)
//   ENB    enable; 0 holds Q and S_OUT
//   DIR    0 = toward MSB (left), 1 = toward LSB (right)
//   S_IN   serial input, sampled only in shift mode
//   MODO   00 shift, 01 rotate, 10 parallel load, 11 hold
//   D      parallel load data, sampled only in load mode
//   Q      register contents (registered)
//   S_OUT  bit shifted out in shift mode, else 0 (registered)
//   ZERO   (REGISTRO_ZERO_FLAG_EN only) Q == 0
//
// WIDTH must be at least 2; the shift slices below assume that.

module registro_desplazable #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ENB,
    input  logic             DIR,
    input  logic             S_IN,
    input  logic [1:0]       MODO,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             S_OUT
`ifdef REGISTRO_ZERO_FLAG_EN
    ,
    output logic             ZERO
`endif
);

    localparam logic [1:0] MODO_SHIFT  = 2'b00;
    localparam logic [1:0] MODO_ROTATE = 2'b01;
    localparam logic [1:0] MODO_LOAD   = 2'b10;
    localparam logic [1:0] MODO_HOLD   = 2'b11;

    logic [WIDTH-1:0] q_nxt;
    logic             s_out_nxt;

    // Next-state decode for an enabled, non-reset edge.
    always_comb begin
        q_nxt     = Q;
        s_out_nxt = 1'b0;
        unique case (MODO)
            MODO_SHIFT: begin
                if (DIR == 1'b0) begin
                    q_nxt     = {Q[WIDTH-2:0], S_IN};
                    s_out_nxt = Q[WIDTH-1];
                end else begin
                    q_nxt     = {S_IN, Q[WIDTH-1:1]};
                    s_out_nxt = Q[0];
                end
            end
            MODO_ROTATE: begin
                // The bit leaving one end re-enters at the other, so S_OUT stays 0.
                if (DIR == 1'b0) begin
                    q_nxt = {Q[WIDTH-2:0], Q[WIDTH-1]};
                end else begin
                    q_nxt = {Q[0], Q[WIDTH-1:1]};
                end
            end
            MODO_LOAD: begin
                q_nxt = D;
            end
            MODO_HOLD: begin
                q_nxt = Q;
            end
            default: begin
                q_nxt = Q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Q     <= '0;
            S_OUT <= 1'b0;
        end else if (ENB) begin
            Q     <= q_nxt;
            S_OUT <= s_out_nxt;
        end
    end

`ifdef REGISTRO_ZERO_FLAG_EN
    assign ZERO = (Q == '0);
`endif

endmodule

// File: tb/tb_registro_desplazable.sv
// Directed-vector bench for registro_desplazable (WIDTH=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Exercises reset, enable hold, load, rotate/shift both ways, hold mode, optional ZERO.

module tb_registro_desplazable;

    localparam int WIDTH = 4;

    logic             clk;
    logic             rst_n;
    logic             ENB;
    logic             DIR;
    logic             S_IN;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             S_OUT;
`ifdef REGISTRO_ZERO_FLAG_EN
    logic             ZERO;
`endif

    int vectors;
    int miscompares;

    logic [WIDTH-1:0] exp_q [4];
    logic             exp_s [4];

    registro_desplazable #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ENB   (ENB),
        .DIR   (DIR),
        .S_IN  (S_IN),
        .MODO  (MODO),
        .D     (D),
        .Q     (Q),
        .S_OUT (S_OUT)
`ifdef REGISTRO_ZERO_FLAG_EN
        ,
        .ZERO  (ZERO)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [WIDTH-1:0] val);
        ENB  = 1'b1;
        MODO = 2'b10;
        D    = val;
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b1;
        ENB   = 1'b0;
        DIR   = 1'b0;
        S_IN  = 1'b0;
        MODO  = 2'b11;
        D     = '0;
        tick();

        // Put 1010 in the register so reset has something to clear.
        load(4'b1010);
        chk("preload_q", Q, 4'b1010);

        // Reset wins over ENB/MODO: a load of 1111 is requested on the same edge.
        rst_n = 1'b0;
        ENB   = 1'b1;
        MODO  = 2'b10;
        D     = 4'b1111;
        tick();
        chk("rst_q", Q, 4'b0000);
        chk("rst_s", {3'b000, S_OUT}, 4'b0000);
`ifdef REGISTRO_ZERO_FLAG_EN
        chk("rst_zero", {3'b000, ZERO}, 4'b0001);
`endif
        rst_n = 1'b1;

        // ENB=0 with a pending load: nothing changes for two edges.
        ENB = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("hold_enb%0d_q", i), Q, 4'b0000);
        end

        // Load then rotate right four times.
        load(4'b0001);
        chk("load0001_q", Q, 4'b0001);
        exp_q = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        MODO = 2'b01;
        DIR  = 1'b1;
        S_IN = 1'b1;  // must be ignored in rotate
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rotr%0d_q", i), Q, exp_q[i]);
            chk($sformatf("rotr%0d_s", i), {3'b000, S_OUT}, 4'b0000);
        end

        // Load then rotate left four times.
        load(4'b1001);
        chk("load1001_q", Q, 4'b1001);
        exp_q = '{4'b0011, 4'b0110, 4'b1100, 4'b1001};
        MODO = 2'b01;
        DIR  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rotl%0d_q", i), Q, exp_q[i]);
            chk($sformatf("rotl%0d_s", i), {3'b000, S_OUT}, 4'b0000);
        end

        // Shift left, S_IN=1.
        load(4'b1000);
        exp_q = '{4'b0001, 4'b0011, 4'b0111, 4'b0111};
        exp_s = '{1'b1, 1'b0, 1'b0, 1'b0};
        MODO = 2'b00;
        DIR  = 1'b0;
        S_IN = 1'b1;
        D    = 4'b1111;  // must be ignored in shift
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("shl%0d_q", i), Q, exp_q[i]);
            chk($sformatf("shl%0d_s", i), {3'b000, S_OUT}, {3'b000, exp_s[i]});
        end

        // Shift right, S_IN=0.
        load(4'b0101);
        exp_q = '{4'b0010, 4'b0001, 4'b0000, 4'b0000};
        exp_s = '{1'b1, 1'b0, 1'b1, 1'b0};
        MODO = 2'b00;
        DIR  = 1'b1;
        S_IN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("shr%0d_q", i), Q, exp_q[i]);
            chk($sformatf("shr%0d_s", i), {3'b000, S_OUT}, {3'b000, exp_s[i]});
        end

        // ENB=0 keeps S_OUT=1 from the last shift as well as Q.
        ENB  = 1'b0;
        MODO = 2'b10;
        D    = 4'b1010;
        tick();
        chk("enb0_q", Q, 4'b0000);
        chk("enb0_s", {3'b000, S_OUT}, 4'b0001);

        // A shift leaves S_OUT=1, then load clears it.
        ENB  = 1'b1;
        load(4'b0110);
        chk("load0110_q", Q, 4'b0110);
        chk("load0110_s", {3'b000, S_OUT}, 4'b0000);
        MODO = 2'b00;
        DIR  = 1'b0;
        S_IN = 1'b0;
        tick();  // 0110 -> 1100, S_OUT=0
        tick();  // 1100 -> 1000, S_OUT=1
        chk("pre_hold_s", {3'b000, S_OUT}, 4'b0001);
        load(4'b0110);

        // Mode 11: Q holds and S_OUT is 0.
        MODO = 2'b11;
        D    = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("mode11_%0d_q", i), Q, 4'b0110);
            chk($sformatf("mode11_%0d_s", i), {3'b000, S_OUT}, 4'b0000);
        end
`ifdef REGISTRO_ZERO_FLAG_EN
        chk("zero_0110", {3'b000, ZERO}, 4'b0000);
        load(4'b0000);
        chk("zero_load0", {3'b000, ZERO}, 4'b0001);
`endif

        // Reset in the middle of a rotate discards it.
        load(4'b1001);
        MODO  = 2'b01;
        DIR   = 1'b0;
        tick();
        chk("mid_rot_q", Q, 4'b0011);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_q", Q, 4'b0000);
        rst_n = 1'b1;
        tick();
        chk("post_rst_rot_q", Q, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
